fifo_sched: RTL and testbench

Access scheduler for the byte FIFO: it arbitrates NREQ producer streams onto the single FIFO write port and presents the FIFO read port as a ready/valid consumer stream. It enforces the FIFO usage rules internally, so client logic never sees them:
- a gap cycle after every push_back, with data_in held;
- no pop when empty;
- no back-to-back pops;
- no pop of a word still being written.

It also owns the FIFO's synchronous reset and flush.

---
 rtl/fifo_sched_pkg.sv | 15 +
 rtl/fifo_sched_rr_arbiter.sv | 31 +++
 rtl/fifo_sched.sv | 154 +++++++++++++++
 tb/tb_fifo_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// fifo_sched shared types.
// Write-FSM states and pointer width helper.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_PUSH = 2'd1,
    W_HOLD = 2'd2
  } wstate_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_sched_rr_arbiter.sv
// Round-robin arbiter, one-hot grant.
// Search starts one past the last winner.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_pointer,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  // first requester at or after pointer+1, wrapping
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(i_pointer) + k) % N;
      if (!o_any && i_req[PW'(j)]) begin
        o_any            = 1'b1;
        o_idx            = PW'(j);
        o_grant[PW'(j)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_sched.sv
// Byte FIFO access scheduler.
// Arbitrates producers onto push, guards pops.
module fifo_sched
  import fifo_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*WIDTH-1:0] in_data,
  output logic [NREQ-1:0]       in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  fifo_rst,
  output logic                  fifo_push_back,
  output logic [WIDTH-1:0]      fifo_data_in,
  output logic                  fifo_pop_front,
  input  logic [WIDTH-1:0]      fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic                  fifo_error,
  output logic                  err
);

  localparam int PW = ptr_width(NREQ);

  wstate_t          r_state;
  logic [PW-1:0]    r_last;
  logic             r_push;
  logic [WIDTH-1:0] r_din;
  logic             r_pop_q;
  logic             r_fresh;
  logic             r_err;
  logic             r_rst0;
  logic             r_rst1;

  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  logic             w_can;
  logic             w_ov;
  logic             w_pop;
  logic [WIDTH-1:0] w_sel;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .i_req     (in_valid),
    .i_pointer (r_last),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  assign w_sel = in_data[int'(w_idx)*WIDTH +: WIDTH];

  assign w_can = (r_state == W_IDLE)
               & !r_rst1 & !flush
               & !fifo_full & w_any;

  assign w_ov = !r_rst1 & !flush & !fifo_empty
              & !r_pop_q & !r_fresh;

  assign w_pop = w_ov & out_ready;

  assign in_ready       = w_can ? w_grant : '0;
  assign out_valid      = w_ov;
  assign fifo_pop_front = w_pop;
  assign out_data       = fifo_data_out;
  assign fifo_push_back = r_push;
  assign fifo_data_in   = r_din;
  assign fifo_rst       = r_rst1;
  assign err            = r_err;

  // two-flop FIFO reset release; flush re-arms one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst0 <= 1'b1;
      r_rst1 <= 1'b1;
    end else if (flush) begin
      r_rst0 <= 1'b0;
      r_rst1 <= 1'b1;
    end else begin
      r_rst0 <= 1'b0;
      r_rst1 <= r_rst0;
    end
  end

  // write FSM: grant, push one cycle, hold data one more
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= W_IDLE;
      r_last  <= PW'(NREQ - 1);
      r_push  <= 1'b0;
      r_din   <= '0;
    end else if (flush) begin
      r_state <= W_IDLE;
      r_push  <= 1'b0;
    end else begin
      unique case (r_state)
        W_IDLE: begin
          if (w_can) begin
            r_din   <= w_sel;
            r_last  <= w_idx;
            r_push  <= 1'b1;
            r_state <= W_PUSH;
          end
        end
        W_PUSH: begin
          r_push  <= 1'b0;
          r_state <= W_HOLD;
        end
        W_HOLD: begin
          r_state <= W_IDLE;
        end
        default: begin
          r_push  <= 1'b0;
          r_state <= W_IDLE;
        end
      endcase
    end
  end

  // read guards: gap after a pop, block word still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_q <= 1'b0;
      r_fresh <= 1'b0;
    end else if (flush) begin
      r_pop_q <= 1'b0;
      r_fresh <= 1'b0;
    end else begin
      r_pop_q <= w_pop;
      r_fresh <= (r_state == W_PUSH) & fifo_empty;
    end
  end

  // sticky error from the FIFO outside its reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (flush) begin
      r_err <= 1'b0;
    end else if (fifo_error && !r_rst1) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_sched.sv
// fifo_sched bench: FIFO stand-in plus
// transaction-level reference model.
module tb_fifo_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;
  localparam int DEPTH = 16;
  localparam int NCYC  = 4000;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic [NREQ-1:0]       in_valid = '0;
  logic [NREQ*WIDTH-1:0] in_data = '0;
  logic [NREQ-1:0]       in_ready;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [WIDTH-1:0]      out_data;
  logic                  fifo_rst;
  logic                  fifo_push_back;
  logic [WIDTH-1:0]      fifo_data_in;
  logic                  fifo_pop_front;
  logic [WIDTH-1:0]      fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_error;
  logic                  err;
  logic                  inj_err = 1'b0;

  always #5 clk = ~clk;

  fifo_sched #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .fifo_rst       (fifo_rst),
    .fifo_push_back (fifo_push_back),
    .fifo_data_in   (fifo_data_in),
    .fifo_pop_front (fifo_pop_front),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_error     (fifo_error),
    .err            (err)
  );

  // FIFO stand-in: count moves at the push edge,
  // the word lands one edge later; flags rule breaks
  logic [WIDTH-1:0] fm_mem [DEPTH];
  int               fm_cnt = 0;
  int               fm_rd = 0;
  int               fm_wr = 0;
  int               fm_waddr = 0;
  logic             fm_wpend = 1'b0;
  logic             fm_err = 1'b0;

  always @(posedge clk) begin
    if (fifo_rst) begin
      fm_cnt   <= 0;
      fm_rd    <= 0;
      fm_wr    <= 0;
      fm_wpend <= 1'b0;
      fm_err   <= 1'b0;
    end else begin
      if (fm_wpend) fm_mem[fm_waddr] <= fifo_data_in;
      fm_wpend <= 1'b0;
      if (fifo_push_back) begin
        if (fm_cnt == DEPTH && !fifo_pop_front)
          fm_err <= 1'b1;
        fm_waddr <= fm_wr;
        fm_wpend <= 1'b1;
        fm_wr    <= (fm_wr + 1) % DEPTH;
      end
      if (fifo_pop_front) begin
        if (fm_cnt == 0) fm_err <= 1'b1;
        if (fm_wpend && fm_rd == fm_waddr)
          fm_err <= 1'b1;
        fm_rd <= (fm_rd + 1) % DEPTH;
      end
      fm_cnt <= fm_cnt + int'(fifo_push_back)
                       - int'(fifo_pop_front);
    end
  end

  assign fifo_empty    = (fm_cnt == 0);
  assign fifo_full     = (fm_cnt == DEPTH);
  assign fifo_data_out = fm_mem[fm_rd];
  assign fifo_error    = fm_err | inj_err;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp,
                       input int cyc);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] d;
    int               c;
  } ent_t;

  ent_t             sb[$];
  int               last_g;
  int               since;
  logic             exp_frst;
  logic             frst_pend;
  logic             popped_prev;
  logic             exp_err;
  logic [WIDTH-1:0] exp_din;

  task automatic model_reset();
    sb.delete();
    last_g      = NREQ - 1;
    since       = 3;
    exp_frst    = 1'b1;
    frst_pend   = 1'b1;
    popped_prev = 1'b0;
    exp_err     = 1'b0;
    exp_din     = '0;
  endtask

  task automatic drive(input int c);
    rst_n = !(c < 3 || (c >= 2000 && c < 2003));
    flush   = ($urandom_range(0, 199) == 0);
    inj_err = ($urandom_range(0, 249) == 0);
    in_data = NREQ*WIDTH'($urandom());
    if (c < 40) begin
      flush     = 1'b0;
      in_valid  = '1;
      out_ready = 1'b1;
    end else if (c >= 300 && c < 420) begin
      flush     = 1'b0;
      in_valid  = '1;
      out_ready = 1'b0;
    end else if (c >= 1000 && c < 1100) begin
      in_valid  = '1;
      out_ready = 1'b1;
    end else if (c >= 1200 && c < 1300) begin
      in_valid  = NREQ'(1);
      out_ready = 1'b1;
    end else begin
      in_valid  = NREQ'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic step(input int cyc);
    int               g;
    int               j;
    logic             can;
    logic             eov;
    logic             epop;
    logic [NREQ-1:0]  eg;
    ent_t             e;
    if (!rst_n) begin
      model_reset();
      check("rst_in_ready", 32'(in_ready), 0, cyc);
      check("rst_out_valid", 32'(out_valid), 0, cyc);
      check("rst_fifo_rst", 32'(fifo_rst), 1, cyc);
      check("rst_push", 32'(fifo_push_back), 0, cyc);
      check("rst_pop", 32'(fifo_pop_front), 0, cyc);
      check("rst_data_in", 32'(fifo_data_in), 0, cyc);
      check("rst_err", 32'(err), 0, cyc);
      return;
    end
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      j = (last_g + k) % NREQ;
      if (g < 0 && in_valid[j]) g = j;
    end
    can = (since >= 3) && !exp_frst && !flush
        && !fifo_full && (g >= 0);
    eg = can ? (NREQ'(1) << g) : '0;
    eov = !exp_frst && !flush && !popped_prev
        && (sb.size() > 0) && (cyc - sb[0].c >= 3);
    epop = eov && out_ready;
    check("in_ready", 32'(in_ready), 32'(eg), cyc);
    check("out_valid", 32'(out_valid), 32'(eov), cyc);
    check("pop_front", 32'(fifo_pop_front),
          32'(epop), cyc);
    check("push_back", 32'(fifo_push_back),
          32'(since == 1), cyc);
    check("data_in", 32'(fifo_data_in),
          32'(exp_din), cyc);
    check("fifo_rst", 32'(fifo_rst), 32'(exp_frst), cyc);
    check("err", 32'(err), 32'(exp_err), cyc);
    check("fifo_rules", 32'(fm_err), 0, cyc);
    if (epop)
      check("out_data", 32'(out_data),
            32'(sb[0].d), cyc);
    if (flush) begin
      sb.delete();
      since       = 3;
      popped_prev = 1'b0;
      exp_err     = 1'b0;
      exp_frst    = 1'b1;
    end else begin
      if (epop) void'(sb.pop_front());
      if (can) begin
        e.d     = in_data[g*WIDTH +: WIDTH];
        e.c     = cyc;
        sb.push_back(e);
        last_g  = g;
        exp_din = e.d;
        since   = 0;
      end
      if (since < 3) since++;
      popped_prev = epop;
      if (fifo_error && !exp_frst) exp_err = 1'b1;
      exp_frst = frst_pend;
    end
    frst_pend = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      @(negedge clk);
      step(c);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
